// File: rtl/add_rkey_bank.sv
// AddRoundKey stage with a bank of NKEYS round keys written by index; each block is XORed with
// the key its round tag selects. Valid/ready handshake, optionally registered output.
module add_rkey_bank #(
    parameter int unsigned DW       = 128,
    parameter int unsigned NKEYS    = 11,
    parameter int unsigned AW       = 4,
    parameter int unsigned PIPE     = 1,
    parameter int unsigned REQ_LOAD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_we,
    input  logic [AW-1:0] key_addr,
    input  logic [DW-1:0] key_din,
    input  logic          key_clr,
    output logic          keys_loaded,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_round,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_round,
    output logic [DW-1:0] out_data,
    output logic [1:0]    err
);

    localparam logic [AW:0] NK = (AW+1)'(NKEYS);

    logic [DW-1:0]    key_q [NKEYS];
    logic [NKEYS-1:0] mask_q;
    logic [1:0]       err_q;
    logic [DW-1:0]    key_sel;
    logic [DW-1:0]    xor_data;
    logic             addr_ok;
    logic             round_ok;
    logic             load_ok;
    logic             accept;

    assign addr_ok     = {1'b0, key_addr} < NK;
    assign round_ok    = {1'b0, in_round} < NK;
    assign keys_loaded = &mask_q;
    assign load_ok     = keys_loaded || (REQ_LOAD == 0);
    assign accept      = in_valid && in_ready;
    assign err         = err_q;

    // Out-of-range round tags match no entry, so the key defaults to zero.
    always_comb begin
        key_sel = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (in_round == AW'(i)) key_sel = key_q[i];
        end
    end

    assign xor_data = in_data ^ key_sel;

    always_ff @(posedge clk) begin
        if (rst || key_clr) begin
            for (int i = 0; i < NKEYS; i++) key_q[i] <= '0;
            mask_q <= '0;
        end else if (key_we && addr_ok) begin
            for (int i = 0; i < NKEYS; i++) begin
                if (key_addr == AW'(i)) begin
                    key_q[i]  <= key_din;
                    mask_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            if (key_we && !addr_ok)   err_q[0] <= 1'b1;
            if (accept && !round_ok)  err_q[1] <= 1'b1;
        end
    end

    if (PIPE != 0) begin : g_pipe
        logic          out_valid_q;
        logic [DW-1:0] out_data_q;
        logic [AW-1:0] out_round_q;

        assign in_ready  = (!out_valid_q || out_ready) && load_ok;
        assign out_valid = out_valid_q;
        assign out_data  = out_data_q;
        assign out_round = out_round_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                out_round_q <= '0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= xor_data;
                out_round_q <= in_round;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end else begin : g_comb
        assign in_ready  = out_ready && load_ok;
        assign out_valid = in_valid && load_ok;
        assign out_data  = xor_data;
        assign out_round = in_round;
    end

endmodule

// File: tb/tb_add_rkey_bank.sv
// Directed bench for add_rkey_bank: a registered (PIPE=1) and a combinational (PIPE=0) instance
// share clock, reset and the key-write bus.
module tb_add_rkey_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_we, key_clr;
    logic [3:0]   key_addr;
    logic [127:0] key_din;

    logic         in_valid, in_ready, out_valid, out_ready, keys_loaded;
    logic [3:0]   in_round, out_round;
    logic [127:0] in_data, out_data;
    logic [1:0]   err;

    logic         in_valid0, in_ready0, out_valid0, out_ready0, keys_loaded0;
    logic [3:0]   in_round0, out_round0;
    logic [127:0] in_data0, out_data0;
    logic [1:0]   err0;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    add_rkey_bank #(.DW(128), .NKEYS(11), .AW(4), .PIPE(1), .REQ_LOAD(1)) dut (
        .clk(clk), .rst(rst), .key_we(key_we), .key_addr(key_addr), .key_din(key_din),
        .key_clr(key_clr), .keys_loaded(keys_loaded), .in_valid(in_valid), .in_ready(in_ready),
        .in_round(in_round), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_round(out_round), .out_data(out_data), .err(err)
    );

    add_rkey_bank #(.DW(128), .NKEYS(11), .AW(4), .PIPE(0), .REQ_LOAD(1)) dut0 (
        .clk(clk), .rst(rst), .key_we(key_we), .key_addr(key_addr), .key_din(key_din),
        .key_clr(key_clr), .keys_loaded(keys_loaded0), .in_valid(in_valid0),
        .in_ready(in_ready0), .in_round(in_round0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_round(out_round0),
        .out_data(out_data0), .err(err0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{4'd3,  {16{8'hFF}}, {16{8'hFC}}};
        vecs[1] = '{4'd0,  {16{8'h3C}}, {16{8'h3C}}};
        vecs[2] = '{4'd10, {16{8'h55}}, {16{8'h5F}}};
        vecs[3] = '{4'd6,  {16{8'hA5}}, {16{8'hA3}}};
        vecs[4] = '{4'd7,  {16{8'h00}}, {16{8'h07}}};
        vecs[5] = '{4'd9,  {16{8'h80}}, {16{8'h89}}};
        vecs[6] = '{4'd1,  {16{8'hF0}}, {16{8'hF1}}};

        rst = 1'b1; key_we = 1'b0; key_clr = 1'b0; key_addr = '0; key_din = '0;
        in_valid = 1'b0; in_round = '0; in_data = '0; out_ready = 1'b1;
        in_valid0 = 1'b1; in_round0 = '0; in_data0 = '0; out_ready0 = 1'b1;

        // Reset
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_keys_loaded", keys_loaded, 0);
        check("rst_err", err, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_p0_out_valid", out_valid0, 0);
        check("rst_p0_in_ready", in_ready0, 0);

        // Load key schedule key[i] = i replicated per byte
        for (int i = 0; i < 11; i++) begin
            key_we = 1'b1; key_addr = 4'(i); key_din = {16{8'(i)}};
            if (i == 10) check("loaded_before_last", keys_loaded, 0);
            tick();
        end
        key_we = 1'b0;
        check("loaded_after_last", keys_loaded, 1);
        check("ready_after_load", in_ready, 1);

        for (int v = 0; v < 7; v++) begin
            in_valid = 1'b1; in_round = vecs[v].round; in_data = vecs[v].data;
            tick();
            check($sformatf("vec%0d_valid", v), out_valid, 1);
            check($sformatf("vec%0d_data", v), out_data, vecs[v].exp);
            check($sformatf("vec%0d_round", v), out_round, vecs[v].round);
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);

        // PIPE=0: combinational path
        in_round0 = 4'd3; in_data0 = {16{8'hFF}}; #1;
        check("p0_data_r3", out_data0, {16{8'hFC}});
        check("p0_round", out_round0, 4'd3);
        check("p0_valid", out_valid0, 1);
        in_round0 = 4'd8; in_data0 = {16{8'h01}}; out_ready0 = 1'b0; #1;
        check("p0_data_r8", out_data0, {16{8'h09}});
        check("p0_ready_low", in_ready0, 0);
        out_ready0 = 1'b1; #1;
        check("p0_ready_high", in_ready0, 1);

        // Backpressure: A held, B waits, both emerge once in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_round = 4'd2; in_data = {16{8'h11}};
        tick();
        check("bp_a_valid", out_valid, 1);
        check("bp_a_data", out_data, {16{8'h13}});
        check("bp_in_ready", in_ready, 0);
        in_round = 4'd4; in_data = {16{8'h20}};
        tick(); tick();
        check("bp_a_held", out_data, {16{8'h13}});
        check("bp_a_round_held", out_round, 4'd2);
        check("bp_still_blocked", in_ready, 0);
        out_ready = 1'b1; #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_b_data", out_data, {16{8'h24}});
        check("bp_b_round", out_round, 4'd4);
        check("bp_b_valid", out_valid, 1);
        tick();
        check("bp_b_once", out_valid, 0);

        // Out-of-range write and round tag
        key_we = 1'b1; key_addr = 4'd12; key_din = {16{8'hEE}};
        tick();
        key_we = 1'b0;
        check("oor_err0", err, 2'b01);
        in_valid = 1'b0; in_round = 4'd14;
        tick();
        check("oor_err1_no_accept", err, 2'b01);
        in_valid = 1'b1; in_round = 4'd4; in_data = {16{8'h00}};
        tick();
        check("oor_store_intact", out_data, {16{8'h04}});
        in_round = 4'd14; in_data = {16{8'h5A}};
        tick();
        in_valid = 1'b0;
        check("oor_round_passthru", out_data, {16{8'h5A}});
        check("oor_err1", err, 2'b11);

        // Write/read collision on key 5: old key used, new key next block
        key_we = 1'b1; key_addr = 4'd5; key_din = {16{8'hAA}};
        in_valid = 1'b1; in_round = 4'd5; in_data = {16{8'h0F}};
        tick();
        key_we = 1'b0;
        check("coll_old_key", out_data, {16{8'h0A}});
        tick();
        in_valid = 1'b0;
        check("coll_new_key", out_data, {16{8'hA5}});
        tick();

        // Clear with a block held; clear beats same-cycle write
        out_ready = 1'b0;
        in_valid = 1'b1; in_round = 4'd1; in_data = {16{8'h10}};
        tick();
        in_valid = 1'b0;
        key_clr = 1'b1; key_we = 1'b1; key_addr = 4'd0; key_din = {16{8'h77}};
        tick();
        key_clr = 1'b0; key_we = 1'b0;
        check("clr_keys_loaded", keys_loaded, 0);
        check("clr_in_ready", in_ready, 0);
        check("clr_held_data", out_data, {16{8'h11}});
        check("clr_held_valid", out_valid, 1);
        check("clr_err_kept", err, 2'b11);
        in_round0 = 4'd0; in_data0 = {16{8'h3C}}; #1;
        check("clr_beats_write", out_data0, {16{8'h3C}});
        in_round0 = 4'd3; #1;
        check("clr_zero_keys", out_data0, {16{8'h3C}});
        check("clr_p0_valid", out_valid0, 0);

        // Reset with a block held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_data", out_data, 0);
        check("rst_mid_err", err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
